// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings for the load/store unit: access sizes,
//               lane offsets, FSM states and the alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Big-endian lanes: offset 0 is the most significant byte of the word
    localparam logic [1:0] OFF_B0   = 2'd0;
    localparam logic [1:0] OFF_B1   = 2'd1;
    localparam logic [1:0] OFF_B2   = 2'd2;
    localparam logic [1:0] OFF_B3   = 2'd3;
    localparam logic [1:0] OFF_H_HI = 2'd0;
    localparam logic [1:0] OFF_H_LO = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_DONE    = 3'd4
    } lsu_state_t;

    function automatic logic misaligned(input logic [1:0] off, input logic [1:0] size);
        logic r;
        r = 1'b0;
        case (size)
            SZ_HALF: r = off[0];
            SZ_WORD: r = (off != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane extract (with sign/zero extension) and
//               lane merge for sub-word accesses on a big-endian 32-bit word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] rdata,
    output logic [31:0] merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (off)
            OFF_B0:  w_byte = word[31:24];
            OFF_B1:  w_byte = word[23:16];
            OFF_B2:  w_byte = word[15:8];
            OFF_B3:  w_byte = word[7:0];
            default: w_byte = 8'h00;
        endcase
        w_half = (off[1] == OFF_H_LO[1]) ? word[15:0] : word[31:16];
    end

    always_comb begin
        rdata  = 32'h0;
        merged = word;
        case (size)
            SZ_BYTE: begin
                rdata = {{24{is_signed & w_byte[7]}}, w_byte};
                case (off)
                    OFF_B0:  merged = {wdata[7:0], word[23:0]};
                    OFF_B1:  merged = {word[31:24], wdata[7:0], word[15:0]};
                    OFF_B2:  merged = {word[31:16], wdata[7:0], word[7:0]};
                    OFF_B3:  merged = {word[31:8], wdata[7:0]};
                    default: merged = word;
                endcase
            end
            SZ_HALF: begin
                rdata = {{16{is_signed & w_half[15]}}, w_half};
                if (off[1] == OFF_H_LO[1]) begin
                    merged = {word[31:16], wdata[15:0]};
                end else begin
                    merged = {wdata[15:0], word[15:0]};
                end
            end
            SZ_WORD: begin
                rdata  = word;
                merged = wdata;
            end
            default: begin
                rdata  = 32'h0;
                merged = word;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-stage load/store sequencer in front of a 16-bit
//               halfword memory; read-modify-write for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_HALFWORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    output logic        mem_write_en,
    output logic        mem_read_en,
    input  logic [31:0] mem_data
);

    localparam logic [31:0] c_byte_limit = 32'(2 * MEM_HALFWORDS);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_write;
    logic        r_err;
    logic [31:0] r_wbuf;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_req_err;
    logic [31:0] w_word_idx;
    logic [31:0] w_extract;
    logic [31:0] w_merge;

    assign req_ready  = (r_state == ST_IDLE);
    assign w_accept   = req_valid & req_ready;
    assign w_req_err  = (req_size == SZ_ILLEGAL) | misaligned(req_addr[1:0], req_size)
                      | (req_addr >= c_byte_limit);
    // Halfword index of the upper half of the containing word
    assign w_word_idx = {1'b0, r_addr[31:2], 1'b0};

    lsu_align u_align (
        .word      (mem_data),
        .wdata     (r_wbuf),
        .off       (r_addr[1:0]),
        .size      (r_size),
        .is_signed (r_signed),
        .rdata     (w_extract),
        .merged    (w_merge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next = ST_DONE;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        w_next = ST_WRITE;
                    end else begin
                        w_next = ST_READ;
                    end
                end
            end
            ST_READ:    w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = r_write ? ST_WRITE : ST_DONE;
            ST_WRITE:   w_next = ST_DONE;
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // r_wbuf holds store data until CAPTURE replaces it with the merged word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= 32'h0;
            r_size   <= SZ_BYTE;
            r_signed <= 1'b0;
            r_write  <= 1'b0;
            r_err    <= 1'b0;
            r_wbuf   <= 32'h0;
            r_rdata  <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= req_addr;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_write  <= req_write;
                        r_err    <= w_req_err;
                        r_wbuf   <= req_wdata;
                        r_rdata  <= 32'h0;
                    end
                end
                ST_CAPTURE: begin
                    if (r_write) begin
                        r_wbuf <= w_merge;
                    end else begin
                        r_rdata <= w_extract;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;
        mem_address   = 32'h0;
        mem_writedata = 32'h0;
        resp_valid    = 1'b0;
        resp_err      = 1'b0;
        resp_rdata    = 32'h0;
        case (r_state)
            ST_READ: begin
                mem_read_en = 1'b1;
                mem_address = w_word_idx;
            end
            ST_WRITE: begin
                mem_write_en  = 1'b1;
                mem_address   = w_word_idx;
                mem_writedata = r_wbuf;
            end
            ST_DONE: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
                resp_rdata = r_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
